// File: rtl/shadow_dump_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : shadow_dump_collector_if
// Purpose  : Valid/ready word stream from the dump collector to the host readout.
// Revision : 1.0
// ============================================================================
interface shadow_dump_collector_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/shadow_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : shadow_dump_collector
// Purpose  : Sweeps enabled shadow chains, packs serial bits into 32-bit words
//            with a per-chain trailer, and streams them out through a FWFT FIFO.
// Revision : 1.0
// ============================================================================
module shadow_dump_collector #(
    parameter int CHAINS     = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic              sh_clk,
    input  wire logic              sh_rst,
    input  wire logic              start_i,
    input  wire logic [CHAINS-1:0] chain_mask_i,
    output logic      [CHAINS-1:0] dump_en_o,
    input  wire logic [CHAINS-1:0] ch_out_i,
    input  wire logic [CHAINS-1:0] ch_out_vld_i,
    input  wire logic [CHAINS-1:0] ch_out_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    shadow_dump_collector_if.master out_if
);

    localparam int IW = (CHAINS > 1) ? $clog2(CHAINS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_STALL = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0] LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW:0] IDX_END   = (IW+1)'(CHAINS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_DUMP  = 3'd2,
        S_TRAIL = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    logic [CHAINS-1:0] mask_q;
    logic [IW:0]       idx_q;
    logic [31:0]       acc_q;
    logic [4:0]        bitpos_q;
    logic [15:0]       bitcnt_q;
    logic              busy_q;
    logic              done_q;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [AW:0]       cnt_q;

    logic [IW-1:0]     w_sel;
    logic              w_grant;
    logic              w_bit;
    logic              w_vld;
    logic              w_done;
    logic              w_full;
    logic              w_pop;
    logic              w_push_d;
    logic [31:0]       w_push_data_d;
    logic [7:0]        w_idx8;

    assign w_sel   = idx_q[IW-1:0];
    assign w_idx8  = 8'(idx_q);
    assign w_full  = (cnt_q == LVL_FULL);
    // A grant needs two free slots so a trailing partial word plus trailer always fit.
    assign w_grant = (state_q == S_DUMP) && (cnt_q <= LVL_STALL);
    assign w_bit   = ch_out_i[w_sel];
    assign w_vld   = w_grant & ch_out_vld_i[w_sel];
    assign w_done  = w_grant & ch_out_done_i[w_sel];
    assign w_pop   = out_if.out_valid & out_if.out_ready;

    assign dump_en_o        = w_grant ? ({{(CHAINS-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign out_if.out_valid = (cnt_q != '0);
    assign out_if.out_data  = out_if.out_valid ? mem_q[rptr_q] : 32'h0;

    always_comb begin
        w_push_d      = 1'b0;
        w_push_data_d = 32'h0;
        if (state_q == S_DUMP) begin
            if (w_vld && (bitpos_q == 5'd31)) begin
                w_push_d      = 1'b1;
                w_push_data_d = {w_bit, acc_q[30:0]};
            end
        end else if ((state_q == S_TRAIL) && !w_full) begin
            w_push_d      = 1'b1;
            w_push_data_d = (bitpos_q != 5'd0) ? acc_q : {8'hA5, w_idx8, bitcnt_q};
        end
    end

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            idx_q    <= '0;
            acc_q    <= 32'h0;
            bitpos_q <= 5'd0;
            bitcnt_q <= 16'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mask_q  <= chain_mask_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (idx_q >= IDX_END) begin
                        state_q <= S_DRAIN;
                    end else if (mask_q[w_sel]) begin
                        state_q <= S_DUMP;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DUMP: begin
                    if (w_vld) begin
                        if (bitpos_q == 5'd31) begin
                            acc_q <= 32'h0;
                        end else begin
                            acc_q[bitpos_q] <= w_bit;
                        end
                        bitpos_q <= bitpos_q + 5'd1;
                        if (bitcnt_q != 16'hFFFF) begin
                            bitcnt_q <= bitcnt_q + 16'd1;
                        end
                    end
                    if (w_done) begin
                        state_q <= S_TRAIL;
                    end
                end
                S_TRAIL: begin
                    if (!w_full) begin
                        if (bitpos_q != 5'd0) begin
                            bitpos_q <= 5'd0;
                            acc_q    <= 32'h0;
                        end else begin
                            bitcnt_q <= 16'h0;
                            idx_q    <= idx_q + 1'b1;
                            state_q  <= S_SEEK;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sh_clk) begin
        if (w_push_d) begin
            mem_q[wptr_q] <= w_push_data_d;
        end
    end

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_push_d) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({w_push_d, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shadow_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_shadow_dump_collector
// Purpose  : Directed vector table plus hand sequences for stall, reset and start corner cases.
// Revision : 1.0
// ============================================================================
module tb_shadow_dump_collector;
    localparam int CH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CH-1:0] mask_i;
    logic [CH-1:0] dump_en;
    logic [CH-1:0] ch_out;
    logic [CH-1:0] ch_vld;
    logic [CH-1:0] ch_done;
    logic          busy;
    logic          done;

    shadow_dump_collector_if oif ();

    shadow_dump_collector #(.CHAINS(CH), .FIFO_DEPTH(16)) u_dut (
        .sh_clk        (clk),
        .sh_rst        (rst),
        .start_i       (start_i),
        .chain_mask_i  (mask_i),
        .dump_en_o     (dump_en),
        .ch_out_i      (ch_out),
        .ch_out_vld_i  (ch_vld),
        .ch_out_done_i (ch_done),
        .busy_o        (busy),
        .done_o        (done),
        .out_if        (oif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]    mask;
        int               ca, na, cb, nb;
        bit               ones, dlast;
        int               nexp;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs [5];

    int            checks = 0;
    int            failures = 0;
    int            cfg_ch [2];
    int            cfg_n [2];
    bit            cfg_act [2];
    bit            cfg_ones, cfg_dlast;
    int            sent [2];
    bit            fin [2];
    bit            last_vld [2];
    bit            last_done [2];
    logic [CH-1:0] last_en;
    logic [31:0]   got [$];
    int            done_cnt;
    bit            start_req;
    logic [CH-1:0] mask_req;
    bit            ready_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int ca, input int na, input int cb, input int nb,
                           input bit ones, input bit dlast);
        cfg_ch[0] = ca; cfg_n[0] = na; cfg_act[0] = (ca >= 0);
        cfg_ch[1] = cb; cfg_n[1] = nb; cfg_act[1] = (cb >= 0);
        cfg_ones = ones; cfg_dlast = dlast;
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; fin[k] = 1'b0; last_vld[k] = 1'b0; last_done[k] = 1'b0;
        end
        got.delete();
        done_cnt = 0;
    endtask

    // One clock: account for what the last edge consumed, drive producers, sample outputs.
    task automatic cycle();
        int c;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cfg_act[k] && last_en[cfg_ch[k]]) begin
                if (last_vld[k]) sent[k]++;
                if (last_done[k]) fin[k] = 1'b1;
            end
        end
        last_en = dump_en;
        ch_out  = {$urandom, $urandom};
        ch_vld  = {$urandom, $urandom};
        ch_done = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            last_vld[k] = 1'b0; last_done[k] = 1'b0;
            if (cfg_act[k] && !fin[k]) begin
                c = cfg_ch[k];
                last_vld[k]  = (sent[k] < cfg_n[k]);
                last_done[k] = (sent[k] >= cfg_n[k]) || (cfg_dlast && sent[k] == cfg_n[k] - 1);
                ch_vld[c]    = last_vld[k];
                ch_done[c]   = last_done[k];
                if (last_vld[k]) ch_out[c] = cfg_ones ? 1'b1 : (sent[k] % 2 == 0);
            end
        end
        start_i = start_req;
        mask_i  = mask_req;
        start_req = 1'b0;
        oif.out_ready = ready_req;
        if (oif.out_valid && oif.out_ready) got.push_back(oif.out_data);
        if (done) done_cnt++;
    endtask

    task automatic finish_sweep(input string tag, input logic [31:0] exp [$]);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            cycle();
            t++;
        end
        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_nwords"}, 64'(got.size()), 64'(exp.size()));
        for (int j = 0; j < exp.size(); j++) begin
            chk($sformatf("%s_w%0d", tag, j), (j < got.size()) ? 64'(got[j]) : 64'hx, 64'(exp[j]));
        end
        cycle();
        chk({tag, "_donepulse"}, 64'(done), 64'd0);
    endtask

    task automatic set_vec(input int i, input logic [CH-1:0] m, input int ca, input int na,
                           input int cb, input int nb, input bit ones, input bit dlast,
                           input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        vecs[i].mask = m; vecs[i].ca = ca; vecs[i].na = na; vecs[i].cb = cb; vecs[i].nb = nb;
        vecs[i].ones = ones; vecs[i].dlast = dlast; vecs[i].nexp = n;
        vecs[i].exp[0] = w0; vecs[i].exp[1] = w1; vecs[i].exp[2] = w2; vecs[i].exp[3] = w3;
    endtask

    task automatic run_vec(input int i);
        logic [31:0] exp [$];
        set_cfg(vecs[i].ca, vecs[i].na, vecs[i].cb, vecs[i].nb, vecs[i].ones, vecs[i].dlast);
        for (int j = 0; j < vecs[i].nexp; j++) exp.push_back(vecs[i].exp[j]);
        ready_req = 1'b1;
        mask_req  = vecs[i].mask;
        start_req = 1'b1;
        cycle();
        finish_sweep($sformatf("vec%0d", i), exp);
    endtask

    initial begin
        logic [31:0] exp [$];
        logic [31:0] hold;
        logic [CH-1:0] m;

        m = '0;
        set_vec(0, 64'h1,                    0, 40, -1, 0, 1'b0, 1'b0, 3,
                32'h55555555, 32'h00000055, 32'hA5000028, 32'h0);
        set_vec(1, (64'h1 << 3) | (64'h1 << 5), 3, 32, 5, 0, 1'b1, 1'b0, 3,
                32'hFFFFFFFF, 32'hA5030020, 32'hA5050000, 32'h0);
        set_vec(2, 64'h1 << 63,              63, 33, -1, 0, 1'b0, 1'b1, 3,
                32'h55555555, 32'h00000001, 32'hA53F0021, 32'h0);
        set_vec(3, 64'h1 << 10,              10, 32, -1, 0, 1'b0, 1'b0, 2,
                32'h55555555, 32'hA50A0020, 32'h0, 32'h0);
        set_vec(4, 64'h1 << 1,               1, 1, -1, 0, 1'b0, 1'b1, 2,
                32'h00000001, 32'hA5010001, 32'h0, 32'h0);

        rst = 1'b1; start_i = 1'b0; mask_i = '0; ch_out = '0; ch_vld = '0; ch_done = '0;
        oif.out_ready = 1'b1; ready_req = 1'b1; start_req = 1'b0; mask_req = '0; last_en = '0;
        set_cfg(-1, 0, -1, 0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("rst_dump_en", 64'(dump_en), 64'd0);
        chk("rst_valid", 64'(oif.out_valid), 64'd0);
        chk("rst_data", 64'(oif.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: 520 bits must stall the producer at exactly 15 buffered words.
        set_cfg(0, 520, -1, 0, 1'b0, 1'b0);
        ready_req = 1'b0; mask_req = 64'h1; start_req = 1'b1;
        cycle();
        repeat (700) cycle();
        chk("stall_dump_en", 64'(dump_en), 64'd0);
        chk("stall_sent", 64'(sent[0]), 64'd480);
        chk("stall_valid", 64'(oif.out_valid), 64'd1);
        hold = oif.out_data;
        repeat (5) cycle();
        chk("stall_hold", 64'(oif.out_data), 64'(hold));
        chk("stall_head", 64'(hold), 64'h55555555);
        ready_req = 1'b1;
        exp.delete();
        for (int j = 0; j < 16; j++) exp.push_back(32'h55555555);
        exp.push_back(32'h00000055);
        exp.push_back(32'hA5000208);
        finish_sweep("stall", exp);

        // Asynchronous reset in the middle of a chain.
        set_cfg(0, 520, -1, 0, 1'b0, 1'b0);
        ready_req = 1'b1; mask_req = 64'h1; start_req = 1'b1;
        cycle();
        repeat (60) cycle();
        chk("pre_rst_grant", 64'(dump_en[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dump_en", 64'(dump_en), 64'd0);
        chk("arst_valid", 64'(oif.out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        repeat (3) cycle();
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        run_vec(0);

        // Second start while busy is ignored.
        set_cfg(2, 8, -1, 0, 1'b0, 1'b0);
        mask_req = 64'h1 << 2; start_req = 1'b1;
        cycle();
        repeat (5) cycle();
        mask_req = m; start_req = 1'b1;
        cycle();
        exp.delete();
        exp.push_back(32'h00000055);
        exp.push_back(32'hA5020008);
        finish_sweep("busystart", exp);
        repeat (100) cycle();
        chk("busystart_once", 64'(done_cnt), 64'd1);

        // Empty mask: sweep completes with no words.
        set_cfg(-1, 0, -1, 0, 1'b0, 1'b0);
        mask_req = m; start_req = 1'b1;
        cycle();
        cycle();
        chk("empty_busy", 64'(busy), 64'd1);
        exp.delete();
        finish_sweep("empty", exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
